// File: rtl/divider_config_loader.sv
// Serial loader for a clock divider's divide target. A 16-bit word arrives
// MSB first on an asynchronous target_clock/target_data pair. It is range
// checked, and is then applied only at a safe point: a divider count-complete
// strobe, or any cycle while the divider is disabled.
module divider_config_loader #(
  parameter logic [15:0] DEFAULT_TARGET = 16'd10,
  parameter logic [15:0] MIN_TARGET     = 16'd2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        pulse_clock,
  input  logic        external_reset,
  input  logic        target_data,
  input  logic        target_clock,
  input  logic        enable,
  input  logic        divider_toggle,
  output logic [15:0] divider_target,
  output logic        target_update,
  output logic        config_busy,
  output logic        config_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, PENDING} state_t;

  state_t        state, state_nxt;
  logic          tclk_p0, tclk_p1, tclk_p2;
  logic          tdata_p0, tdata_p1;
  logic          bit_edge;
  logic [15:0]   shift_reg, shift_nxt;
  logic [15:0]   pend_reg, pend_nxt;
  logic [15:0]   target_nxt;
  logic [4:0]    bit_cnt, bit_cnt_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic          update_nxt;
  logic          error_nxt;

  // Timeout counter increment that holds at its ceiling instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v >= TMO_MAX) ? TMO_MAX : v + TW'(1);
  endfunction

  // Two-flop synchronizers; the third target_clock flop supplies edge history.
  always_ff @(posedge pulse_clock or posedge external_reset) begin
    if (external_reset) begin
      tclk_p0  <= 1'b0;
      tclk_p1  <= 1'b0;
      tclk_p2  <= 1'b0;
      tdata_p0 <= 1'b0;
      tdata_p1 <= 1'b0;
    end else begin
      tclk_p0  <= target_clock;
      tclk_p1  <= tclk_p0;
      tclk_p2  <= tclk_p1;
      tdata_p0 <= target_data;
      tdata_p1 <= tdata_p0;
    end
  end

  // -- synchronized stage: rising edge of the serial clock --
  assign bit_edge    = tclk_p1 & ~tclk_p2;
  assign config_busy = (state != IDLE);

  // Next-state and datapath updates for the frame FSM.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    pend_nxt    = pend_reg;
    target_nxt  = divider_target;
    bit_cnt_nxt = bit_cnt;
    tmo_nxt     = tmo_cnt;
    update_nxt  = 1'b0;
    error_nxt   = config_error;
    case (state)
      IDLE: begin
        if (bit_edge) begin
          shift_nxt   = {15'd0, tdata_p1};
          bit_cnt_nxt = 5'd1;
          tmo_nxt     = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_edge) begin
          shift_nxt   = {shift_reg[14:0], tdata_p1};
          bit_cnt_nxt = bit_cnt + 5'd1;
          tmo_nxt     = '0;
          if (bit_cnt == 5'd15) state_nxt = CHECK;
        end else if (tmo_cnt >= TMO_LAST) begin
          // Serial source stalled mid-frame: drop the partial word.
          shift_nxt   = '0;
          bit_cnt_nxt = '0;
          tmo_nxt     = '0;
          error_nxt   = 1'b1;
          state_nxt   = IDLE;
        end else begin
          tmo_nxt = sat_inc(tmo_cnt);
        end
      end
      CHECK: begin
        bit_cnt_nxt = '0;
        tmo_nxt     = '0;
        if (shift_reg < MIN_TARGET) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          pend_nxt  = shift_reg;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        // Serial edges are ignored here; only a safe apply point matters.
        if (divider_toggle || !enable) begin
          target_nxt = pend_reg;
          update_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and register bank; reset restores defaults and discards any frame.
  always_ff @(posedge pulse_clock or posedge external_reset) begin
    if (external_reset) begin
      state          <= IDLE;
      shift_reg      <= '0;
      pend_reg       <= '0;
      divider_target <= DEFAULT_TARGET;
      bit_cnt        <= '0;
      tmo_cnt        <= '0;
      target_update  <= 1'b0;
      config_error   <= 1'b0;
    end else begin
      state          <= state_nxt;
      shift_reg      <= shift_nxt;
      pend_reg       <= pend_nxt;
      divider_target <= target_nxt;
      bit_cnt        <= bit_cnt_nxt;
      tmo_cnt        <= tmo_nxt;
      target_update  <= update_nxt;
      config_error   <= error_nxt;
    end
  end

endmodule
